vc_arbiter: RTL and testbench
=============================

Name: vc_arbiter

Overview:
- Upstream control stage for the two-VC output multiplexer.
- Every cycle it decides which virtual-channel FIFO, VC0 or VC1, is popped, or that neither is.
- Drives the combinational FIFO pops and the one-cycle-delayed pop qualifiers (pop_delay_vc0/pop_delay_vc1) that the mux uses as data enables.
- VC0 has strict priority, bounded by a starvation guard for VC1.
- Grants are blocked when the head word's destination FIFO (D0/D1) is almost full.

Parameters:
- MAX_STARVE, 4: consecutive VC0 grants allowed while VC1 is eligible before VC1 is forced a grant (valid range 1..15).
- CNT_W, 16: width of the statistics counters (used only with the optional feature).

Ports:
- clk  input  1  system clock, all state on rising edge
- reset_L  input  1  asynchronous active-low reset
- vc0_empty  input  1  VC0 FIFO empty
- vc1_empty  input  1  VC1 FIFO empty
- vc0_dest  input  1  destination of VC0 head word (0=D0, 1=D1)
- vc1_dest  input  1  destination of VC1 head word
- d0_almost_full  input  1  D0 FIFO almost full
- d1_almost_full  input  1  D1 FIFO almost full
- pop_vc0  output  1  combinational pop to VC0 FIFO
- pop_vc1  output  1  combinational pop to VC1 FIFO
- pop_delay_vc0  output  1  pop_vc0 registered one cycle (mux enable)
- pop_delay_vc1  output  1  pop_vc1 registered one cycle (mux enable)
- arb_state  output  2  current FSM state, for debug

Behaviour:
- Reset (reset_L=0, asynchronous):
  - state=IDLE, starve_cnt=0.
  - pop_delay_vc0=pop_delay_vc1=0.
  - pop_vc0/pop_vc1 forced 0 while reset_L=0.
- Eligibility, combinational:
  - elig0 = !vc0_empty && !(vc0_dest ? d1_almost_full : d0_almost_full).
  - elig1 = the same expression using vc1_* signals.
- Grant, combinational and same cycle:
  - force1 = elig1 && (starve_cnt == MAX_STARVE).
  - pop_vc1 = elig1 && (!elig0 || force1).
  - pop_vc0 = elig0 && !force1.
  - pop_vc0 and pop_vc1 are never both 1.
  - An empty FIFO is never popped.
- FSM states: IDLE=0, GNT0=1, GNT1=2; value 3 unused and recovers to IDLE.
  - Next state is GNT0 if pop_vc0, GNT1 if pop_vc1, else IDLE.
  - Transition is independent of the current state; the state records the last grant.
- Starvation counter (4 bits):
  - On pop_vc0 with elig1=1: increment.
  - On pop_vc1: clear to 0.
  - When elig1=0: clear to 0.
  - Never exceeds MAX_STARVE.
- pop_delay_vcX <= pop_vcX on each clk edge. Latency 1 cycle, aligned with FIFO read data reaching the mux.
- Simultaneous almost-full on both D0 and D1: no grant, state goes to IDLE, starve_cnt holds.
- Almost-full asserting mid-stream: it takes effect the same cycle with no extra pop. Headroom is provided by the FIFO almost-full threshold (at least 2 entries).
- Reset asserted mid-operation: outputs clear immediately; any pop_delay in flight is discarded.

Optional Feature:
- Macro VC_ARB_STATS_EN.
- When defined:
  - Adds outputs gnt0_cnt and gnt1_cnt (CNT_W each), counting pop_vc0/pop_vc1 grants, saturating at all-ones.
  - Adds output stall_cnt (CNT_W), counting cycles where !vc0_empty || !vc1_empty but no grant, saturating.
  - All three counters reset to 0 on reset_L=0.
- When undefined: these ports and their logic are absent, and the rest of the behaviour is identical.

Test Plan:
- Reset: reset_L=0 with vc0_empty=0 and no almost-full -> pop_vc0=0, pop_delay_vc0=0, arb_state=0. Release reset -> pop_vc0=1 in the same cycle, pop_delay_vc0=1 one edge later.
- Priority: both VCs non-empty, dest=0, d0_almost_full=0, MAX_STARVE=4 -> grant pattern over 10 cycles is 0,0,0,0,1,0,0,0,0,1 (VC0 grants, then forced VC1).
- Backpressure: vc0_dest=1, d1_almost_full=1, vc1 non-empty with dest=0 -> pop_vc1=1 and pop_vc0=0. Deassert d1_almost_full -> pop_vc0=1 the same cycle.
- Both destinations almost full, both VCs non-empty -> no pops for 5 cycles, arb_state=IDLE, starve_cnt unchanged. Clear -> grants resume on VC0.
- Empty guard: vc0_empty=vc1_empty=1 for 3 cycles -> pop_vc0=pop_vc1=0 and pop_delay_vc*=0. Mid-stream reset pulse -> pop_delay_vc* is 0 immediately.
- With VC_ARB_STATS_EN defined: 6 VC0 grants, 2 VC1 grants, 3 stall cycles -> gnt0_cnt=6, gnt1_cnt=2, stall_cnt=3.

Source files
------------

// File: rtl/vc_arbiter.sv
// vc_arbiter: chooses which virtual-channel FIFO (VC0 or VC1) is popped each
// cycle for the two-VC output multiplexer. VC0 has strict priority, and a
// starvation guard forces a VC1 grant after MAX_STARVE consecutive VC0 grants
// while VC1 is waiting. No grant is issued when the head word's destination
// FIFO is almost full.
//
// Optional feature: define VC_ARB_STATS_EN to add saturating grant and stall
// counters (parameter CNT_W and ports gnt0_cnt, gnt1_cnt, stall_cnt).
//
// Ports:
//   clk, reset_L            clock, asynchronous active-low reset
//   vc0_empty, vc1_empty    VC FIFO empty flags
//   vc0_dest, vc1_dest      head-word destination (0=D0, 1=D1)
//   d0_almost_full,
//   d1_almost_full          destination FIFO almost-full flags
//   pop_vc0, pop_vc1        combinational FIFO pops
//   pop_delay_vc0/1         pops registered one cycle (mux data enables)
//   arb_state               current FSM state (debug)
//   gnt0_cnt, gnt1_cnt,
//   stall_cnt               statistics (VC_ARB_STATS_EN only)
module vc_arbiter #(
   parameter int unsigned MAX_STARVE = 4
`ifdef VC_ARB_STATS_EN
   ,
   parameter int unsigned CNT_W      = 16
`endif
) (
   input  logic             clk,
   input  logic             reset_L,
   input  logic             vc0_empty,
   input  logic             vc1_empty,
   input  logic             vc0_dest,
   input  logic             vc1_dest,
   input  logic             d0_almost_full,
   input  logic             d1_almost_full,
   output logic             pop_vc0,
   output logic             pop_vc1,
   output logic             pop_delay_vc0,
   output logic             pop_delay_vc1,
`ifdef VC_ARB_STATS_EN
   output logic [CNT_W-1:0] gnt0_cnt,
   output logic [CNT_W-1:0] gnt1_cnt,
   output logic [CNT_W-1:0] stall_cnt,
`endif
   output logic [1:0]       arb_state
);

   localparam int unsigned STARVE_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT0 = 2'd1,
      GNT1 = 2'd2
   } arb_state_e;

   arb_state_e          state_q, state_d;
   logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;
   logic                pop_delay_vc0_q, pop_delay_vc0_d;
   logic                pop_delay_vc1_q, pop_delay_vc1_d;

   logic elig0, elig1, force1, both_af;

   // Eligibility: non-empty and destination has room.
   assign elig0   = !vc0_empty && !(vc0_dest ? d1_almost_full : d0_almost_full);
   assign elig1   = !vc1_empty && !(vc1_dest ? d1_almost_full : d0_almost_full);
   assign both_af = d0_almost_full && d1_almost_full;
   assign force1  = elig1 && (starve_cnt_q == STARVE_W'(MAX_STARVE));

   // Same-cycle grant; gated by reset so no pop leaks out while held in reset.
   assign pop_vc1 = reset_L && elig1 && (!elig0 || force1);
   assign pop_vc0 = reset_L && elig0 && !force1;

   // Next state records the last grant, independent of the current state.
   always_comb begin
      state_d = IDLE;
      if (pop_vc0) begin
         state_d = GNT0;
      end else if (pop_vc1) begin
         state_d = GNT1;
      end
   end

   // Starvation counter; holds while both destinations are blocked.
   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (both_af) begin
         starve_cnt_d = starve_cnt_q;
      end else if (pop_vc1 || !elig1) begin
         starve_cnt_d = '0;
      end else if (pop_vc0 && (starve_cnt_q < STARVE_W'(MAX_STARVE))) begin
         starve_cnt_d = starve_cnt_q + STARVE_W'(1);
      end
   end

   always_comb begin
      pop_delay_vc0_d = pop_vc0;
      pop_delay_vc1_d = pop_vc1;
   end

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         state_q         <= IDLE;
         starve_cnt_q    <= '0;
         pop_delay_vc0_q <= 1'b0;
         pop_delay_vc1_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         starve_cnt_q    <= starve_cnt_d;
         pop_delay_vc0_q <= pop_delay_vc0_d;
         pop_delay_vc1_q <= pop_delay_vc1_d;
      end
   end

   assign pop_delay_vc0 = pop_delay_vc0_q;
   assign pop_delay_vc1 = pop_delay_vc1_q;
   assign arb_state     = state_q;

`ifdef VC_ARB_STATS_EN
   logic [CNT_W-1:0] gnt0_cnt_q, gnt0_cnt_d;
   logic [CNT_W-1:0] gnt1_cnt_q, gnt1_cnt_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic             stall;

   // A stall is any cycle with work queued but no grant.
   assign stall = (!vc0_empty || !vc1_empty) && !pop_vc0 && !pop_vc1;

   // Saturating statistics counters.
   always_comb begin
      gnt0_cnt_d  = gnt0_cnt_q;
      gnt1_cnt_d  = gnt1_cnt_q;
      stall_cnt_d = stall_cnt_q;
      if (pop_vc0 && (gnt0_cnt_q != '1)) begin
         gnt0_cnt_d = gnt0_cnt_q + CNT_W'(1);
      end
      if (pop_vc1 && (gnt1_cnt_q != '1)) begin
         gnt1_cnt_d = gnt1_cnt_q + CNT_W'(1);
      end
      if (stall && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         gnt0_cnt_q  <= '0;
         gnt1_cnt_q  <= '0;
         stall_cnt_q <= '0;
      end else begin
         gnt0_cnt_q  <= gnt0_cnt_d;
         gnt1_cnt_q  <= gnt1_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign gnt0_cnt  = gnt0_cnt_q;
   assign gnt1_cnt  = gnt1_cnt_q;
   assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_vc_arbiter.sv
// Directed self-checking bench for vc_arbiter (MAX_STARVE=4).
module tb_vc_arbiter;

   logic       clk = 1'b0;
   logic       reset_L;
   logic       vc0_empty, vc1_empty, vc0_dest, vc1_dest;
   logic       d0_almost_full, d1_almost_full;
   logic       pop_vc0, pop_vc1, pop_delay_vc0, pop_delay_vc1;
   logic [1:0] arb_state;
`ifdef VC_ARB_STATS_EN
   logic [15:0] gnt0_cnt, gnt1_cnt, stall_cnt;
`endif

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   vc_arbiter #(
      .MAX_STARVE(4)
`ifdef VC_ARB_STATS_EN
      ,
      .CNT_W(16)
`endif
   ) dut (
      .clk           (clk),
      .reset_L       (reset_L),
      .vc0_empty     (vc0_empty),
      .vc1_empty     (vc1_empty),
      .vc0_dest      (vc0_dest),
      .vc1_dest      (vc1_dest),
      .d0_almost_full(d0_almost_full),
      .d1_almost_full(d1_almost_full),
      .pop_vc0       (pop_vc0),
      .pop_vc1       (pop_vc1),
      .pop_delay_vc0 (pop_delay_vc0),
      .pop_delay_vc1 (pop_delay_vc1),
`ifdef VC_ARB_STATS_EN
      .gnt0_cnt      (gnt0_cnt),
      .gnt1_cnt      (gnt1_cnt),
      .stall_cnt     (stall_cnt),
`endif
      .arb_state     (arb_state)
   );

   task automatic test_reset();
      reset_L = 1'b0;
      vc0_empty = 1'b0; vc1_empty = 1'b1;
      vc0_dest = 1'b0; vc1_dest = 1'b0;
      d0_almost_full = 1'b0; d1_almost_full = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      tests_run++;
      if (pop_vc0 !== 1'b0) begin
         tests_failed++; $display("FAIL reset_pop_vc0 got %b want 0", pop_vc0);
      end
      tests_run++;
      if (pop_delay_vc0 !== 1'b0) begin
         tests_failed++; $display("FAIL reset_pop_delay_vc0 got %b want 0", pop_delay_vc0);
      end
      tests_run++;
      if (arb_state !== 2'd0) begin
         tests_failed++; $display("FAIL reset_arb_state got %0d want 0", arb_state);
      end
      @(negedge clk); reset_L = 1'b1; #1;
      tests_run++;
      if (pop_vc0 !== 1'b1) begin
         tests_failed++; $display("FAIL release_pop_vc0 got %b want 1", pop_vc0);
      end
      @(posedge clk); #1;
      tests_run++;
      if (pop_delay_vc0 !== 1'b1) begin
         tests_failed++; $display("FAIL release_pop_delay_vc0 got %b want 1", pop_delay_vc0);
      end
      tests_run++;
      if (arb_state !== 2'd1) begin
         tests_failed++; $display("FAIL release_arb_state got %0d want 1", arb_state);
      end
   endtask

   // Both eligible: four VC0 grants, then a forced VC1 grant, repeating.
   task automatic test_priority();
      logic [9:0] exp1;
      exp1 = 10'b1000010000; // bit i = VC1 granted in cycle i
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (i == 0) begin
            vc0_empty = 1'b0; vc1_empty = 1'b0;
            vc0_dest = 1'b0; vc1_dest = 1'b0;
            d0_almost_full = 1'b0; d1_almost_full = 1'b0;
         end
         #1;
         tests_run++;
         if (pop_vc1 !== exp1[i] || pop_vc0 !== !exp1[i]) begin
            tests_failed++;
            $display("FAIL priority_cycle%0d got vc0=%b vc1=%b want vc0=%b vc1=%b",
                     i, pop_vc0, pop_vc1, !exp1[i], exp1[i]);
         end
         if (i > 0) begin
            tests_run++;
            if (pop_delay_vc1 !== exp1[i-1] || pop_delay_vc0 !== !exp1[i-1]) begin
               tests_failed++;
               $display("FAIL priority_delay%0d got d0=%b d1=%b want d0=%b d1=%b",
                        i, pop_delay_vc0, pop_delay_vc1, !exp1[i-1], exp1[i-1]);
            end
         end
      end
   endtask

   task automatic test_backpressure();
      @(negedge clk);
      vc0_empty = 1'b0; vc1_empty = 1'b0;
      vc0_dest = 1'b1; vc1_dest = 1'b0;
      d0_almost_full = 1'b0; d1_almost_full = 1'b1;
      #1;
      tests_run++;
      if (pop_vc1 !== 1'b1 || pop_vc0 !== 1'b0) begin
         tests_failed++;
         $display("FAIL bp_blocked got vc0=%b vc1=%b want vc0=0 vc1=1", pop_vc0, pop_vc1);
      end
      @(negedge clk);
      d1_almost_full = 1'b0;
      #1;
      tests_run++;
      if (pop_vc0 !== 1'b1 || pop_vc1 !== 1'b0) begin
         tests_failed++;
         $display("FAIL bp_released got vc0=%b vc1=%b want vc0=1 vc1=0", pop_vc0, pop_vc1);
      end
   endtask

   // Starve count built to 2 must survive a both-full stall.
   task automatic test_both_full();
      logic [2:0] exp1;
      exp1 = 3'b100;
      @(negedge clk);
      vc0_empty = 1'b0; vc1_empty = 1'b1;
      vc0_dest = 1'b0; vc1_dest = 1'b0;
      d0_almost_full = 1'b0; d1_almost_full = 1'b0;
      @(negedge clk); vc1_empty = 1'b0;
      @(negedge clk);
      @(negedge clk);
      d0_almost_full = 1'b1; d1_almost_full = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (i > 0) @(negedge clk);
         #1;
         tests_run++;
         if (pop_vc0 !== 1'b0 || pop_vc1 !== 1'b0) begin
            tests_failed++;
            $display("FAIL bothfull_pop%0d got vc0=%b vc1=%b want 0 0", i, pop_vc0, pop_vc1);
         end
         if (i > 0) begin
            tests_run++;
            if (arb_state !== 2'd0) begin
               tests_failed++;
               $display("FAIL bothfull_state%0d got %0d want 0", i, arb_state);
            end
         end
      end
      @(negedge clk);
      d0_almost_full = 1'b0; d1_almost_full = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (i > 0) @(negedge clk);
         #1;
         tests_run++;
         if (pop_vc1 !== exp1[i] || pop_vc0 !== !exp1[i]) begin
            tests_failed++;
            $display("FAIL bothfull_resume%0d got vc0=%b vc1=%b want vc0=%b vc1=%b",
                     i, pop_vc0, pop_vc1, !exp1[i], exp1[i]);
         end
      end
   endtask

   task automatic test_empty_guard();
      @(negedge clk);
      vc0_empty = 1'b1; vc1_empty = 1'b1;
      for (int i = 0; i < 3; i++) begin
         if (i > 0) @(negedge clk);
         #1;
         tests_run++;
         if (pop_vc0 !== 1'b0 || pop_vc1 !== 1'b0) begin
            tests_failed++;
            $display("FAIL empty_pop%0d got vc0=%b vc1=%b want 0 0", i, pop_vc0, pop_vc1);
         end
         if (i > 0) begin
            tests_run++;
            if (pop_delay_vc0 !== 1'b0 || pop_delay_vc1 !== 1'b0) begin
               tests_failed++;
               $display("FAIL empty_delay%0d got d0=%b d1=%b want 0 0",
                        i, pop_delay_vc0, pop_delay_vc1);
            end
         end
      end
      @(negedge clk); vc0_empty = 1'b0;
      @(posedge clk); #1;
      tests_run++;
      if (pop_delay_vc0 !== 1'b1) begin
         tests_failed++; $display("FAIL midreset_pre got %b want 1", pop_delay_vc0);
      end
      #1 reset_L = 1'b0;
      #1;
      tests_run++;
      if (pop_delay_vc0 !== 1'b0 || pop_vc0 !== 1'b0 || arb_state !== 2'd0) begin
         tests_failed++;
         $display("FAIL midreset_clear got d0=%b pop0=%b state=%0d want 0 0 0",
                  pop_delay_vc0, pop_vc0, arb_state);
      end
      @(negedge clk); reset_L = 1'b1;
   endtask

`ifdef VC_ARB_STATS_EN
   task automatic test_stats();
      @(negedge clk);
      reset_L = 1'b0;
      vc0_empty = 1'b1; vc1_empty = 1'b1;
      vc0_dest = 1'b0; vc1_dest = 1'b0;
      d0_almost_full = 1'b0; d1_almost_full = 1'b0;
      @(negedge clk); reset_L = 1'b1;
      for (int i = 0; i < 11; i++) begin
         @(negedge clk);
         if (i < 6) begin
            vc0_empty = 1'b0; vc1_empty = 1'b1;
            d0_almost_full = 1'b0; d1_almost_full = 1'b0;
         end else if (i < 8) begin
            vc0_empty = 1'b1; vc1_empty = 1'b0;
         end else begin
            vc0_empty = 1'b0; vc1_empty = 1'b1;
            d0_almost_full = 1'b1; d1_almost_full = 1'b1;
         end
      end
      @(negedge clk);
      vc0_empty = 1'b1; vc1_empty = 1'b1;
      d0_almost_full = 1'b0; d1_almost_full = 1'b0;
      #1;
      tests_run++;
      if (gnt0_cnt !== 16'd6) begin
         tests_failed++; $display("FAIL stats_gnt0 got %0d want 6", gnt0_cnt);
      end
      tests_run++;
      if (gnt1_cnt !== 16'd2) begin
         tests_failed++; $display("FAIL stats_gnt1 got %0d want 2", gnt1_cnt);
      end
      tests_run++;
      if (stall_cnt !== 16'd3) begin
         tests_failed++; $display("FAIL stats_stall got %0d want 3", stall_cnt);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_priority();
      test_backpressure();
      test_both_full();
      test_empty_guard();
`ifdef VC_ARB_STATS_EN
      test_stats();
`endif
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
